nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit CLA reused over WIDTH/4 cycles, LS nibble first.
// Optional macro NIBBLE_SUB_EN adds a 'sub' port for A-B via ~B + 1.
module nsa_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             ovf,
  output logic             busy
);
  localparam int NN = WIDTH / 4;
  localparam int IW = $clog2(NN) + 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s_nib;
  logic             w_c_nib;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_init;

`ifdef NIBBLE_SUB_EN
  // subtract as A + ~B + 1; carry_in is ignored then
  assign w_b_eff  = sub ? ~in1 : in1;
  assign w_c_init = sub | carry_in;
`else
  assign w_b_eff  = in1;
  assign w_c_init = carry_in;
`endif

  assign w_a_nib = r_a[4*r_idx +: 4];
  assign w_b_nib = r_b[4*r_idx +: 4];

  nsa_cla4 u_cla (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .i_c (r_carry),
    .o_s (w_s_nib),
    .o_c (w_c_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in0;
            r_b     <= w_b_eff;
            r_carry <= w_c_init;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[4*r_idx +: 4] <= w_s_nib;
          r_carry             <= w_c_nib;
          r_idx               <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_cout  <= w_c_nib;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                    && (w_s_nib[3] != r_a[WIDTH-1]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl, WIDTH=16.
// Subtract vectors run only when NIBBLE_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        carry_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .carry_in  (carry_in),
`ifdef NIBBLE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // accept, wait for DONE, hold 3 cycles, release
  task automatic run_op(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic cin,
                        input logic s,
                        input logic [15:0] es,
                        input logic ec,
                        input logic eo);
    int lat;
    @(negedge clk);
    in0 = a; in1 = b; carry_in = cin; sub = s;
    in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in0 = ~a; in1 = ~b; carry_in = ~cin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, 4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, carry_out, ec);
    check({tag, ".ovf"}, ovf, eo);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_ov"}, out_valid, 1);
      check({tag, ".hold_sum"}, {sum, carry_out, ovf}, {es, ec, eo});
      check({tag, ".hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, ".idle_rdy"}, in_ready, 1);
    check({tag, ".idle_ov"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, ".noqueue"}, busy, 0);
    check({tag, ".idle_sum"}, {sum, carry_out, ovf}, {es, ec, eo});
  endtask

  initial begin
    int first, second, cyc, seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in0 = 16'h1111; in1 = 16'h2222; carry_in = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rdy", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.ov", out_valid, 0);
    check("rst.out", {sum, carry_out, ovf}, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;

    run_op("ffff+1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("1234c",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_op("7fff+1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("8000x2",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("ripple",  16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("mixed",   16'hA5C3, 16'h3C5A, 1'b0, 1'b0, 16'hE21D, 1'b0, 1'b0);

    // abort in the second RUN cycle
    @(negedge clk);
    in0 = 16'h1111; in1 = 16'h1111; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.rdy", in_ready, 1);
    check("abort.busy", busy, 0);
    check("abort.sum", {sum, carry_out, ovf}, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort.noov", seen, 0);
    run_op("post",    16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

    // back-to-back spacing with out_ready held high
    @(negedge clk);
    in0 = 16'h0001; in1 = 16'h0001; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (in_ready) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("tput.gap", second - first, 6);
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    check("tput.sum", sum, 16'h0002);
    check("tput.idle", busy, 0);

`ifdef NIBBLE_SUB_EN
    run_op("5-7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("8000-1",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
